// File: rtl/io_bus_responder_if.sv
// Data-memory bus and TX byte stream seen by the I/O responder.
interface io_bus_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    modport master (
        output Address, WriteData, MemWrite, MemRead, TxReady,
        input  ReadData, Hit, TxData, TxValid
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, TxReady,
        output ReadData, Hit, TxData, TxValid
    );
endinterface

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: PortOut, synchronized PortIn, TX byte FIFO.
// Optional change detection on PortIn is built when IO_RESPONDER_CHANGE_DETECT_EN is defined.
module io_bus_responder #(
    parameter logic [31:0] IO_BASE    = 32'h1001_0040,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    io_bus_responder_if.slave      bus,
    input  logic [7:0]             PortIn,
    output logic [31:0]            PortOut,
    output logic                   InChangeIrq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_PORT_OUT = 3'd0;
    localparam logic [2:0] SEL_PORT_IN  = 3'd1;
    localparam logic [2:0] SEL_STATUS   = 3'd2;
    localparam logic [2:0] SEL_CLEAR    = 3'd3;
    localparam logic [2:0] SEL_TX_DATA  = 3'd4;

    logic [7:0]       s1;
    logic [7:0]       in_sync;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             changed;

    logic             hit_c;
    logic [2:0]       sel_c;
    logic             wr_c;
    logic             tx_wr_c;
    logic             clr_wr_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic [31:0]      status_c;
    logic [31:0]      read_data_c;
    logic             unused_c;

    // Address decode and write strobes
    assign hit_c    = (bus.Address[31:5] == IO_BASE[31:5]);
    assign sel_c    = bus.Address[4:2];
    assign wr_c     = hit_c && bus.MemWrite;
    assign tx_wr_c  = wr_c && (sel_c == SEL_TX_DATA);
    assign clr_wr_c = wr_c && (sel_c == SEL_CLEAR);
    assign unused_c = ^bus.Address[1:0];

    // FIFO handshake; a pop in the same cycle frees the slot a full-FIFO push needs
    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(FIFO_DEPTH));
    assign pop_c   = !empty_c && bus.TxReady;
    assign push_c  = tx_wr_c && (!full_c || pop_c);

    assign bus.TxValid = !empty_c;
    assign bus.TxData  = mem[rd_ptr];
    assign bus.Hit     = hit_c;

    assign status_c = {24'b0, 4'(count), overflow, empty_c, full_c, changed};

    // Zero-latency read mux; reads have no side effects
    always_comb begin
        read_data_c = '0;
        if (hit_c && bus.MemRead) begin
            case (sel_c)
                SEL_PORT_OUT: read_data_c = PortOut;
                SEL_PORT_IN:  read_data_c = {24'b0, in_sync};
                SEL_STATUS:   read_data_c = status_c;
                default:      read_data_c = '0;
            endcase
        end
    end
    assign bus.ReadData = read_data_c;

    // Output port register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut <= '0;
        end else if (wr_c && (sel_c == SEL_PORT_OUT)) begin
            PortOut <= bus.WriteData;
        end
    end

    // Two-flop synchronizer for the asynchronous input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= '0;
            in_sync <= '0;
        end else begin
            s1      <= PortIn;
            in_sync <= s1;
        end
    end

`ifdef IO_RESPONDER_CHANGE_DETECT_EN
    logic [7:0] in_prev;

    // Sticky change flag; a new change beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_prev <= '0;
            changed <= 1'b0;
        end else begin
            in_prev <= in_sync;
            if (in_sync != in_prev) begin
                changed <= 1'b1;
            end else if (clr_wr_c && bus.WriteData[0]) begin
                changed <= 1'b0;
            end
        end
    end
`else
    assign changed = 1'b0;
`endif

    assign InChangeIrq = changed;

    // Overflow flag; a dropped push beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (tx_wr_c && !push_c) begin
            overflow <= 1'b1;
        end else if (clr_wr_c && bus.WriteData[3]) begin
            overflow <= 1'b0;
        end
    end

    // Circular buffer storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= bus.WriteData[7:0];
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed test-plan steps then random traffic
// against a queue-based reference model.
module tb_io_bus_responder;

    localparam logic [31:0] BASE  = 32'h1001_0040;
    localparam int          DEPTH = 4;
`ifdef IO_RESPONDER_CHANGE_DETECT_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  port_in = 8'h00;
    logic [31:0] port_out;
    logic        irq;

    io_bus_responder_if bus_if ();

    io_bus_responder #(.IO_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .PortIn      (port_in),
        .PortOut     (port_out),
        .InChangeIrq (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_port_out;
    logic [7:0]  m_samp [3];   // [0]=first stage, [1]=synchronized, [2]=previous synchronized
    bit          m_chg;
    bit          m_ovf;
    logic [7:0]  m_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[7:4] = 4'(m_q.size());
        s[3]   = m_ovf;
        s[2]   = (m_q.size() == 0);
        s[1]   = (m_q.size() == DEPTH);
        s[0]   = m_chg;
        return s;
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic mr);
        if (!(m_hit(a) && mr)) return 32'h0;
        case (a[4:2])
            3'd0:    return m_port_out;
            3'd1:    return {24'h0, m_samp[1]};
            3'd2:    return m_status();
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_clear();
        m_port_out = '0;
        m_samp[0] = '0; m_samp[1] = '0; m_samp[2] = '0;
        m_chg = 1'b0;
        m_ovf = 1'b0;
        m_q.delete();
    endfunction

    // Apply one rising edge worth of behaviour to the model
    function automatic void m_edge(input logic [31:0] a, input logic [31:0] wd,
                                   input logic mw, input logic rdy, input logic [7:0] pin);
        bit wr, pop, tx, push, chg_set;
        wr      = m_hit(a) && mw;
        tx      = wr && (a[4:2] == 3'd4);
        pop     = (m_q.size() != 0) && rdy;
        push    = tx && ((m_q.size() < DEPTH) || pop);
        chg_set = CD && (m_samp[1] != m_samp[2]);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(wd[7:0]);
        if (tx && !push) m_ovf = 1'b1;
        else if (wr && a[4:2] == 3'd3 && wd[3]) m_ovf = 1'b0;
        if (chg_set) m_chg = 1'b1;
        else if (CD && wr && a[4:2] == 3'd3 && wd[0]) m_chg = 1'b0;
        if (wr && a[4:2] == 3'd0) m_port_out = wd;
        m_samp[2] = m_samp[1];
        m_samp[1] = m_samp[0];
        m_samp[0] = pin;
    endfunction

    task automatic post_checks(input string tag);
        check({tag, ":port_out"}, port_out, m_port_out);
        check({tag, ":txvalid"}, 32'(bus_if.TxValid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, ":txdata"}, 32'(bus_if.TxData), 32'(m_q[0]));
        check({tag, ":irq"}, 32'(irq), 32'(m_chg));
    endtask

    // One bus cycle: drive, check combinational read, clock, check registered state
    task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic mw, input logic mr, input logic rdy, input logic [7:0] pin);
        bus_if.Address   = a;
        bus_if.WriteData = wd;
        bus_if.MemWrite  = mw;
        bus_if.MemRead   = mr;
        bus_if.TxReady   = rdy;
        port_in          = pin;
        #1;
        check({tag, ":hit"}, 32'(bus_if.Hit), 32'(m_hit(a)));
        check({tag, ":rdata"}, bus_if.ReadData, m_read(a, mr));
        @(posedge clk);
        m_edge(a, wd, mw, rdy, pin);
        #1;
        post_checks(tag);
    endtask

    task automatic do_reset();
        bus_if.Address   = '0;
        bus_if.WriteData = '0;
        bus_if.MemWrite  = 1'b0;
        bus_if.MemRead   = 1'b0;
        bus_if.TxReady   = 1'b0;
        port_in          = 8'h00;
        reset            = 1'b0;
        #1;
        check("rst:txvalid", 32'(bus_if.TxValid), 32'h0);
        check("rst:txdata", 32'(bus_if.TxData), 32'h0);
        check("rst:port_out", port_out, 32'h0);
        check("rst:irq", 32'(irq), 32'h0);
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [7:0]  pin;
        logic        mw, mr, rdy;
        int          r;

        #1;
        do_reset();

        // Reset state and PORT_OUT round trip
        cycle("status_rst", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("status_rst_const", bus_if.ReadData, 32'h0000_0004);
        cycle("po_wr", BASE, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 8'h00);
        cycle("po_rd", BASE, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("po_rd_const", port_out, 32'hDEAD_BEEF);
        cycle("miss", BASE + 32'h20, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 8'h00);

        // Input synchronization and change flag
        cycle("pin_e1", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);
        cycle("pin_e2", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);
        cycle("pin_e3", BASE + 32'h4, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);
        cycle("pin_st", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);
        cycle("pin_clr", BASE + 32'hC, 32'h1, 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle("pin_st2", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);

        // FIFO fill, overflow, drain
        for (int i = 1; i <= 5; i++)
            cycle("fill", BASE + 32'h10, 32'(i * 8'h11), 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle("fill_st", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 8'hA5);
        for (int i = 0; i < 5; i++)
            cycle("drain", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 8'hA5);
        cycle("ovf_clr", BASE + 32'hC, 32'h8, 1'b1, 1'b0, 1'b0, 8'hA5);

        // Push and pop together on a full FIFO
        for (int i = 0; i < 4; i++)
            cycle("full", BASE + 32'h10, 32'hA1 + 32'(i), 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle("pushpop", BASE + 32'h10, 32'h66, 1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++)
            cycle("drain2", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 8'hA5);

        // Reset with bytes queued
        for (int i = 0; i < 3; i++)
            cycle("queue", BASE + 32'h10, 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0, 8'h3C);
        do_reset();
        for (int i = 0; i < 3; i++)
            cycle("post_rst", BASE + 32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 8'h00);

        // Random traffic
        pin = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + {27'h0, 3'($urandom), 2'($urandom)};
            else if (r == 8) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
            else             a = $urandom;
            wd  = $urandom;
            mw  = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            cycle("rand", a, wd, mw, mr, rdy, pin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O responder on the pipelined core's data-memory bus. It sits beside the data RAM in the ME stage and decodes a 32-byte window at `IO_BASE`. Inside that window it answers the core's `lw`/`sw` accesses. It owns the registered `PortOut`, a synchronized and change-detected view of `PortIn`, and a small transmit FIFO. The FIFO drains over a valid/ready byte interface.

## Interface
Parameters:
- `IO_BASE`, 32'h1001_0040, window base address; bits [4:0] must be 0.
- `FIFO_DEPTH`, 4, number of TX FIFO entries; a power of 2 and at least 2.

Ports:
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Address` in 32: byte address from the core's ALU result in ME.
- `WriteData` in 32: store data from the core.
- `MemWrite` in 1: store strobe.
- `MemRead` in 1: load strobe.
- `ReadData` out 32: load data. Combinational.
- `Hit` out 1: `Address[31:5] == IO_BASE[31:5]`. Used by the top level to mux `ReadData` against the RAM.
- `PortIn` in 8: asynchronous external input.
- `PortOut` out 32: registered output port.
- `TxData` out 8: byte at the FIFO head.
- `TxValid` out 1: FIFO not empty.
- `TxReady` in 1: consumer accepts the byte.
- `InChangeIrq` out 1: level copy of the sticky change flag.

## Operation
- Register select is `Address[4:2]`. `Address[1:0]` is ignored. Accesses are full-word only.
- Offset 0x00 `PORT_OUT`, RW: a write loads `PortOut`; a read returns `PortOut`.
- Offset 0x04 `PORT_IN`, RO: reads `{24'b0, in_sync}`.
- Offset 0x08 `STATUS`, RO, bit fields:
  - bit0: `changed`.
  - bit1: full.
  - bit2: empty.
  - bit3: `overflow`.
  - bits[7:4]: count.
  - All other bits 0.
- Offset 0x0C `CLEAR`, WO:
  - `WriteData[0]=1` clears `changed`.
  - `WriteData[3]=1` clears `overflow`.
- Offset 0x10 `TX_DATA`, WO: pushes `WriteData[7:0]` into the FIFO.
- Offsets 0x14–0x1C: reads return 0; writes are ignored.
- Write-only registers read as 0.
- `ReadData` is 0 unless `Hit && MemRead`. No read has side effects.
- Writes take effect only when `Hit && MemWrite` at the rising edge.
- Input path:
  - Two-flop synchronizer: `PortIn` → `s1` → `in_sync`.
  - `in_prev` holds `in_sync` from the previous cycle.
  - `changed` sets when `in_sync != in_prev`.
- FIFO:
  - Circular buffer with `rd_ptr`/`wr_ptr` and `count` (width $clog2(FIFO_DEPTH)+1).
  - `TxData = mem[rd_ptr]`. `TxValid = (count != 0)`.
  - Pop when `TxValid && TxReady`.
  - Push when a `TX_DATA` write occurs and either (`count < FIFO_DEPTH`) or (a pop happens in the same cycle).
  - A push to a full FIFO with no simultaneous pop is dropped and sets `overflow`.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Set/clear conflicts: a set of `changed` or `overflow` in the same cycle as a `CLEAR` write of that bit wins, and the bit stays 1.

## Timing
- Reset (asserted asynchronously) takes effect immediately:
  - `PortOut`=0, `s1`/`in_sync`/`in_prev`=0.
  - `changed`=0, `overflow`=0.
  - Pointers and count = 0, FIFO storage = 0.
  - Hence `TxValid`=0, `TxData`=0, `InChangeIrq`=0.
- Reset asserted mid-transfer discards FIFO contents. No byte is presented after reset is released until a new push occurs.
- Reads have zero latency (combinational in the same ME cycle), so the ME/WB register captures them.
- A `PORT_OUT` write is visible on `PortOut` after the same rising edge. A `sw` followed by a `lw` on the next instruction reads the new value.
- A `PortIn` change reaches `PORT_IN` after 2 edges. `changed` and `InChangeIrq` rise after the 3rd edge.
- A push into an empty FIFO raises `TxValid` after that edge, with `TxData` equal to the pushed byte.
- Each accepted pop advances the head after the edge.
- Throughput is one byte per cycle with `TxReady` held high.
- `TxData` holds stable while `TxValid && !TxReady`.

## Configuration
- `IO_RESPONDER_CHANGE_DETECT_EN` defined: the `in_prev` register and `changed` flag are built as described.
- Undefined:
  - `in_prev` and `changed` are not built.
  - `STATUS[0]` reads 0 and `InChangeIrq` is tied 0.
  - `CLEAR[0]` is ignored.
  - The synchronizer and `PORT_IN` are unaffected.

## Test plan
- Reset check: hold `reset`=0 then release. Expect `PortOut`=0, `TxValid`=0, `InChangeIrq`=0, and `STATUS` read = 32'h0000_0004.
- `PORT_OUT` round-trip: write 32'hDEAD_BEEF to `IO_BASE+0`. Next cycle `PortOut`=32'hDEAD_BEEF and the read returns the same. An access at `IO_BASE+0x20` gives `Hit`=0 and `ReadData`=0.
- Input change: set `PortIn`=8'hA5. `PORT_IN` reads 32'h0000_00A5 after 2 edges; `STATUS[0]`=1 and `InChangeIrq`=1 after 3 edges. Write 1 to `CLEAR` → `STATUS[0]`=0.
- FIFO fill and overflow: with `TxReady`=0, push 8'h11, 8'h22, 8'h33, 8'h44, 8'h55.
  - `STATUS` shows full=1, count=4, `overflow`=1.
  - Raise `TxReady`: `TxData` sequence is 11, 22, 33, 44, then `TxValid`=0.
- Simultaneous events on a full FIFO: push 8'h66 in the same cycle as a pop. `overflow` is not set, count stays 4, and 8'h66 drains last.
- Mid-operation reset: assert reset with 3 bytes queued. `TxValid` drops immediately, and no stale byte appears after release.
